// File: rtl/rmt_action_pkg.sv
// Shared RMT action-stage definitions: opcodes, action field layout and
// field extraction helpers used by the PHV/ALU bridge.
package rmt_action_pkg;

    localparam int unsigned ACTION_W    = 25;
    localparam int unsigned OPC_LSB     = 21;
    localparam int unsigned OPC_W       = 4;
    localparam int unsigned OP1_LSB     = 16;
    localparam int unsigned OP2_LSB     = 11;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned IMM_W       = 16;
    // Opcode bit that switches op2 from a PHV container to the immediate
    localparam int unsigned OPC_IMM_BIT = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_ADDI = 4'b1001,
        OP_SUBI = 4'b1010
    } alu_op_e;

    typedef logic [ACTION_W-1:0] action_t;

    function automatic logic [OPC_W-1:0] act_opcode(input action_t a);
        return a[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [IDX_W-1:0] act_op1_idx(input action_t a);
        return a[OP1_LSB +: IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] act_op2_idx(input action_t a);
        return a[OP2_LSB +: IDX_W];
    endfunction

    function automatic logic [IMM_W-1:0] act_imm(input action_t a);
        return a[IMM_LSB +: IMM_W];
    endfunction

    // Out-of-range container index falls back to container 0
    function automatic int unsigned sel_index(input logic [IDX_W-1:0] idx, input int unsigned n);
        return (32'(idx) < n) ? 32'(idx) : 32'd0;
    endfunction

endpackage

// File: rtl/phv_out_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads as zero when empty.
module phv_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             not_empty_c,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty_c = (count != '0);
    assign do_pop      = pop & not_empty_c;
    assign head_c      = not_empty_c ? mem[rd_ptr] : '0;

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit flow control upstream must make a write into a full FIFO impossible
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !do_pop && (count == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/phv_alu_bridge.sv
// RMT action-stage bridge: decodes per-container actions into ALU operands,
// tracks each PHV through the ALU latency, merges results and buffers them
// in a credit-protected output FIFO.
// Optional build macro: PHV_ALIGN_CHECK_EN adds the sticky align_err check.
module phv_alu_bridge
    import rmt_action_pkg::*;
#(
    parameter int unsigned STAGE      = 0,
    parameter int unsigned N_CONT     = 8,
    parameter int unsigned CONT_W     = 48,
    parameter int unsigned ACTION_LEN = 25,
    parameter int unsigned ALU_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CONT*CONT_W-1:0]     phv_in,
    input  logic [N_CONT*ACTION_LEN-1:0] action_in,
    input  logic                         phv_in_valid,
    output logic                         phv_in_ready,
    output logic [N_CONT*ACTION_LEN-1:0] alu_action_out,
    output logic [N_CONT-1:0]            alu_action_valid,
    output logic [N_CONT*CONT_W-1:0]     alu_op1_out,
    output logic [N_CONT*CONT_W-1:0]     alu_op2_out,
    input  logic [N_CONT*CONT_W-1:0]     alu_result_in,
    input  logic [N_CONT-1:0]            alu_result_valid,
    output logic [N_CONT*CONT_W-1:0]     phv_out,
    output logic                         phv_out_valid,
    input  logic                         phv_out_ready
`ifdef PHV_ALIGN_CHECK_EN
    ,
    output logic                         align_err
`endif
);

    localparam int unsigned PHV_W = N_CONT * CONT_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + ALU_LAT + 2) + 1;

    if (FIFO_DEPTH < ALU_LAT + 2) begin : g_depth_check
        $error("phv_alu_bridge stage %0d: FIFO_DEPTH must be >= ALU_LAT+2", STAGE);
    end

    logic                accept;
    logic                pop;
    logic                push;
    logic [PHV_W-1:0]    op1_d;
    logic [PHV_W-1:0]    op2_d;
    logic [N_CONT-1:0]   mask_d;
    logic [PHV_W-1:0]    merged;
    logic [PHV_W-1:0]    tag_phv  [ALU_LAT+1];
    logic [N_CONT-1:0]   tag_mask [ALU_LAT+1];
    logic [ALU_LAT:0]    tag_vld;
    logic [CNT_W-1:0]    fifo_count;
    logic [SUM_W-1:0]    credit_use;
    logic                ready_d;

    assign accept = phv_in_valid & phv_in_ready;
    assign pop    = phv_out_valid & phv_out_ready;
    assign push   = tag_vld[ALU_LAT];

    // Action decode and operand selection from the incoming PHV
    always_comb begin
        op1_d  = '0;
        op2_d  = '0;
        mask_d = '0;
        for (int i = 0; i < int'(N_CONT); i++) begin
            action_t          a;
            logic [OPC_W-1:0] opc;
            int unsigned      s1;
            int unsigned      s2;
            a   = ACTION_W'(action_in[i*ACTION_LEN +: ACTION_LEN]);
            opc = act_opcode(a);
            s1  = sel_index(act_op1_idx(a), N_CONT);
            s2  = sel_index(act_op2_idx(a), N_CONT);
            op1_d[i*CONT_W +: CONT_W] = phv_in[s1*CONT_W +: CONT_W];
            if (opc[OPC_IMM_BIT]) begin
                op2_d[i*CONT_W +: CONT_W] = CONT_W'(act_imm(a));
            end else begin
                op2_d[i*CONT_W +: CONT_W] = phv_in[s2*CONT_W +: CONT_W];
            end
            mask_d[i] = (opc != OP_NOP);
        end
    end

    // Issue register feeding the ALU bank; idle cycles drive zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_action_out   <= '0;
            alu_action_valid <= '0;
            alu_op1_out      <= '0;
            alu_op2_out      <= '0;
        end else if (accept) begin
            alu_action_out   <= action_in;
            alu_action_valid <= '1;
            alu_op1_out      <= op1_d;
            alu_op2_out      <= op2_d;
        end else begin
            alu_action_out   <= '0;
            alu_action_valid <= '0;
            alu_op1_out      <= '0;
            alu_op2_out      <= '0;
        end
    end

    // Tag pipeline carrying original PHV and update mask alongside the ALUs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s <= int'(ALU_LAT); s++) begin
                tag_phv[s]  <= '0;
                tag_mask[s] <= '0;
            end
        end else begin
            tag_vld     <= {tag_vld[ALU_LAT-1:0], accept};
            tag_phv[0]  <= phv_in;
            tag_mask[0] <= mask_d;
            for (int s = 1; s <= int'(ALU_LAT); s++) begin
                tag_phv[s]  <= tag_phv[s-1];
                tag_mask[s] <= tag_mask[s-1];
            end
        end
    end

    // Merge ALU results into the PHV at the aligned tag stage
    always_comb begin
        merged = tag_phv[ALU_LAT];
        for (int i = 0; i < int'(N_CONT); i++) begin
`ifdef PHV_ALIGN_CHECK_EN
            if (tag_mask[ALU_LAT][i] && alu_result_valid[i]) begin
`else
            if (tag_mask[ALU_LAT][i]) begin
`endif
                merged[i*CONT_W +: CONT_W] = alu_result_in[i*CONT_W +: CONT_W];
            end
        end
    end

    // Credits: everything accepted but not yet popped, looking one cycle ahead
    always_comb begin
        credit_use = SUM_W'(fifo_count) + SUM_W'(accept) - SUM_W'(pop);
        for (int s = 0; s <= int'(ALU_LAT); s++) begin
            credit_use = credit_use + SUM_W'(tag_vld[s]);
        end
        ready_d = (credit_use < SUM_W'(FIFO_DEPTH));
    end

    // Registered input credit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_in_ready <= 1'b0;
        end else begin
            phv_in_ready <= ready_d;
        end
    end

`ifdef PHV_ALIGN_CHECK_EN
    // Sticky flag for ALU result valids that disagree with the tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (tag_vld[ALU_LAT] ? (alu_result_valid != '1) : (alu_result_valid != '0)) begin
            align_err <= 1'b1;
        end
    end
`else
    // ALU results only ever arrive against a live tag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (tag_vld[ALU_LAT] || (alu_result_valid == '0));
        end
    end
`endif

    phv_out_fifo #(
        .WIDTH (PHV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .wdata       (merged),
        .pop         (pop),
        .head_c      (phv_out),
        .not_empty_c (phv_out_valid),
        .count       (fifo_count)
    );

endmodule

// File: tb/tb_phv_alu_bridge.sv
// Bench for phv_alu_bridge: behavioural ALU bank, scoreboard of expected
// merged PHVs computed directly from the action rules, directed and random traffic.
module tb_phv_alu_bridge;

    localparam int unsigned N_CONT     = 8;
    localparam int unsigned CONT_W     = 48;
    localparam int unsigned ACTION_LEN = 25;
    localparam int unsigned ALU_LAT    = 3;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PW         = N_CONT * CONT_W;
    localparam int unsigned AW         = N_CONT * ACTION_LEN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [PW-1:0]   phv_in = '0;
    logic [AW-1:0]   action_in = '0;
    logic            phv_in_valid = 1'b0;
    logic            phv_in_ready;
    logic [AW-1:0]   alu_action_out;
    logic [N_CONT-1:0] alu_action_valid;
    logic [PW-1:0]   alu_op1_out;
    logic [PW-1:0]   alu_op2_out;
    logic [PW-1:0]   alu_result_in;
    logic [N_CONT-1:0] alu_result_valid;
    logic [PW-1:0]   phv_out;
    logic            phv_out_valid;
    logic            phv_out_ready = 1'b0;
`ifdef PHV_ALIGN_CHECK_EN
    logic            align_err;
`endif

    always #5 clk = ~clk;

    phv_alu_bridge #(
        .STAGE      (0),
        .N_CONT     (N_CONT),
        .CONT_W     (CONT_W),
        .ACTION_LEN (ACTION_LEN),
        .ALU_LAT    (ALU_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .action_in        (action_in),
        .phv_in_valid     (phv_in_valid),
        .phv_in_ready     (phv_in_ready),
        .alu_action_out   (alu_action_out),
        .alu_action_valid (alu_action_valid),
        .alu_op1_out      (alu_op1_out),
        .alu_op2_out      (alu_op2_out),
        .alu_result_in    (alu_result_in),
        .alu_result_valid (alu_result_valid),
        .phv_out          (phv_out),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready)
`ifdef PHV_ALIGN_CHECK_EN
        ,
        .align_err        (align_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural ALU bank ----------------
    function automatic logic [CONT_W-1:0] alu_fn(input logic [24:0] act, input logic [CONT_W-1:0] x,
                                                 input logic [CONT_W-1:0] y);
        case (act[24:21])
            4'b0001, 4'b1001: return x + y;
            4'b0010, 4'b1010: return x - y;
            default:          return 48'h0BAD_0BAD_0BAD;
        endcase
    endfunction

    logic [PW-1:0]     alu_pd [ALU_LAT];
    logic [N_CONT-1:0] alu_pv [ALU_LAT];
    logic [N_CONT-1:0] kill_mask = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(ALU_LAT); s++) begin
                alu_pd[s] <= '0;
                alu_pv[s] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CONT); i++) begin
                alu_pd[0][i*CONT_W +: CONT_W] <= alu_fn(alu_action_out[i*ACTION_LEN +: ACTION_LEN],
                                                        alu_op1_out[i*CONT_W +: CONT_W],
                                                        alu_op2_out[i*CONT_W +: CONT_W]);
            end
            alu_pv[0] <= alu_action_valid;
            for (int s = 1; s < int'(ALU_LAT); s++) begin
                alu_pd[s] <= alu_pd[s-1];
                alu_pv[s] <= alu_pv[s-1];
            end
        end
    end

    assign alu_result_in    = alu_pd[ALU_LAT-1];
    assign alu_result_valid = alu_pv[ALU_LAT-1] & ~kill_mask;

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] ref_merge(input logic [PW-1:0] phv, input logic [AW-1:0] act);
        logic [PW-1:0]   r;
        logic [24:0]     a;
        int              opc, i1, i2;
        longint unsigned x, y;
        r = phv;
        for (int i = 0; i < int'(N_CONT); i++) begin
            a   = act[i*ACTION_LEN +: ACTION_LEN];
            opc = int'(a[24:21]);
            i1  = int'(a[20:16]);
            i2  = int'(a[15:11]);
            if (i1 >= int'(N_CONT)) i1 = 0;
            if (i2 >= int'(N_CONT)) i2 = 0;
            x = 64'(phv[i1*CONT_W +: CONT_W]);
            y = (opc >= 8) ? 64'(a[15:0]) : 64'(phv[i2*CONT_W +: CONT_W]);
            if (opc == 1 || opc == 9)       r[i*CONT_W +: CONT_W] = 48'(x + y);
            else if (opc == 2 || opc == 10) r[i*CONT_W +: CONT_W] = 48'(x - y);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_phv();
        logic [PW-1:0] r;
        for (int i = 0; i < int'(PW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_acts();
        logic [AW-1:0] r;
        logic [3:0]    ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010};
        for (int i = 0; i < int'(N_CONT); i++)
            r[i*ACTION_LEN +: ACTION_LEN] = {ops[$urandom_range(0, 4)], 5'($urandom), 16'($urandom)};
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [PW-1:0] sb [$];
    int n_acc = 0;
    int n_pop = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (phv_in_valid && phv_in_ready) begin
                sb.push_back(ref_merge(phv_in, action_in));
                n_acc++;
            end
            if (phv_out_valid && phv_out_ready) begin
                n_pop++;
                if (sb.size() == 0) check_val("stray_out", PW'(phv_out_valid), '0);
                else                check_val("phv_out", phv_out, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] dphv;
    logic [AW-1:0] dact;
    int a0, p0;

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_in_ready", PW'(phv_in_ready), '0);
        check_val("rst_out_valid", PW'(phv_out_valid), '0);
        check_val("rst_phv_out", phv_out, '0);
        check_val("rst_act_valid", PW'(alu_action_valid), '0);
        check_val("rst_op1", alu_op1_out, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("ready_pre_clk", PW'(phv_in_ready), '0);
        tick();
        check_val("ready_post_clk", PW'(phv_in_ready), PW'(1));
        phv_out_ready = 1'b1;

        // directed: ADD, SUBI, NOP, out-of-range index
        dphv = rand_phv();
        dphv[0 +: 48]   = 48'd5;
        dphv[48 +: 48]  = 48'd3;
        dphv[96 +: 48]  = 48'h20;
        dact = '0;
        dact[0 +: 25]  = {4'b0001, 5'd0, 5'd1, 11'd0};
        dact[50 +: 25] = {4'b1010, 5'd2, 16'h0010};
        dact[75 +: 25] = {4'b0001, 5'd31, 5'd2, 11'd0};
        phv_in = dphv;
        action_in = dact;
        phv_in_valid = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        check_val("issue_valid", PW'(alu_action_valid), PW'(8'hFF));
        check_val("op1_c0", PW'(alu_op1_out[0 +: 48]), PW'(5));
        check_val("op2_c0", PW'(alu_op2_out[0 +: 48]), PW'(3));
        check_val("op1_c2", PW'(alu_op1_out[96 +: 48]), PW'(48'h20));
        check_val("op2_c2_imm", PW'(alu_op2_out[96 +: 48]), PW'(48'h10));
        check_val("op1_c3_idx31", PW'(alu_op1_out[144 +: 48]), PW'(5));
        check_val("act_pass", PW'(alu_action_out), PW'(dact));
        tick();
        check_val("idle_valid", PW'(alu_action_valid), '0);
        check_val("idle_op1", alu_op1_out, '0);
        tick();
        tick();
        check_val("lat_not_yet", PW'(phv_out_valid), '0);
        tick();
        check_val("lat_4_valid", PW'(phv_out_valid), PW'(1));
        check_val("c0_add", PW'(phv_out[0 +: 48]), PW'(8));
        check_val("c1_nop", PW'(phv_out[48 +: 48]), PW'(3));
        check_val("c2_subi", PW'(phv_out[96 +: 48]), PW'(48'h10));
        check_val("c3_add", PW'(phv_out[144 +: 48]), PW'(48'h25));
        check_val("c7_nop", PW'(phv_out[336 +: 48]), PW'(dphv[336 +: 48]));
        repeat (6) tick();

        // backpressure: exactly FIFO_DEPTH accepts, then drain in order
        phv_out_ready = 1'b0;
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin
            phv_in = rand_phv();
            action_in = rand_acts();
            phv_in_valid = 1'b1;
            tick();
        end
        check_val("bp_accepts", PW'(n_acc - a0), PW'(FIFO_DEPTH));
        check_val("bp_ready_low", PW'(phv_in_ready), '0);
        phv_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            phv_in = rand_phv();
            action_in = rand_acts();
            tick();
        end
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin
            phv_in = rand_phv();
            action_in = rand_acts();
            tick();
        end
        check_val("full_rate", PW'(n_acc - a0), PW'(20));
        phv_in_valid = 1'b0;
        repeat (15) tick();
        check_val("bp_drained", PW'(sb.size()), '0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            phv_in = rand_phv();
            action_in = rand_acts();
            phv_in_valid = ($urandom_range(0, 3) != 0);
            phv_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        phv_in_valid = 1'b0;
        phv_out_ready = 1'b1;
        repeat (15) tick();
        check_val("rand_drained", PW'(sb.size()), '0);

        // reset with PHVs in flight
        phv_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            phv_in = rand_phv();
            action_in = rand_acts();
            phv_in_valid = 1'b1;
            tick();
        end
        phv_in_valid = 1'b0;
        check_val("pre_rst_out_valid", PW'(phv_out_valid), PW'(1));
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", PW'(phv_out_valid), '0);
        check_val("mid_rst_phv_out", phv_out, '0);
        check_val("mid_rst_ready", PW'(phv_in_ready), '0);
        check_val("mid_rst_act_valid", PW'(alu_action_valid), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        phv_out_ready = 1'b1;
        p0 = n_pop;
        repeat (15) tick();
        check_val("no_stale_pops", PW'(n_pop - p0), '0);
        phv_in = rand_phv();
        action_in = rand_acts();
        phv_in_valid = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        repeat (8) tick();
        check_val("post_rst_flow", PW'(n_pop - p0), PW'(1));

`ifdef PHV_ALIGN_CHECK_EN
        // alignment error: ALU3 drops its valid at the merge stage
        check_val("align_clean", PW'(align_err), '0);
        kill_mask = 8'b0000_1000;
        phv_in = rand_phv();
        action_in = '0;
        phv_in_valid = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        repeat (6) tick();
        kill_mask = '0;
        check_val("align_set", PW'(align_err), PW'(1));
        repeat (5) tick();
        check_val("align_sticky", PW'(align_err), PW'(1));
        #1 rst_n = 1'b0;
        #1;
        check_val("align_rst", PW'(align_err), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
